// File: rtl/aes_round0_stage.sv
// aes_round0_stage: registered AddRoundKey with round-0 key select, 2-entry skid buffer, tag and beat counter
// Define AES_ROUND0_PARITY_EN to add out_parity, the per-byte XOR reduction of OUT.
module aes_round0_stage #(
  parameter int BLOCK_LENGTH = 128,
  parameter int LANES = 1,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*BLOCK_LENGTH-1:0] IN,
  input  logic [2*BLOCK_LENGTH-1:0]     KEY,
  input  logic                          key_256,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*BLOCK_LENGTH-1:0] OUT,
  output logic                          out_key_256,
  output logic [TAG_W-1:0]              out_tag,
  output logic [CNT_W-1:0]              blk_count
`ifdef AES_ROUND0_PARITY_EN
  ,
  output logic [LANES*BLOCK_LENGTH/8-1:0] out_parity
`endif
);
  localparam int DW = LANES*BLOCK_LENGTH;
`ifdef AES_ROUND0_PARITY_EN
  localparam int PW = DW/8;
  localparam int BW = PW + 1 + TAG_W + DW;
`else
  localparam int BW = 1 + TAG_W + DW;
`endif
  logic [BLOCK_LENGTH-1:0] rk;
  logic [DW-1:0] xd;
  logic [BW-1:0] beat, m_q, m_d, s_q, s_d;
  logic mv_q, mv_d, sv_q, sv_d, acc, emit;
  logic [CNT_W-1:0] cnt_q;
  assign rk = key_256 ? KEY[2*BLOCK_LENGTH-1:BLOCK_LENGTH] : KEY[BLOCK_LENGTH-1:0];
  assign xd = IN ^ {LANES{rk}};
`ifdef AES_ROUND0_PARITY_EN
  logic [PW-1:0] par;
  always_comb begin
    par = '0;
    for (int j = 0; j < PW; j++) par[j] = ^xd[j*8 +: 8];
  end
  assign beat = {par, key_256, in_tag, xd};
  assign {out_parity, out_key_256, out_tag, OUT} = m_q;
`else
  assign beat = {key_256, in_tag, xd};
  assign {out_key_256, out_tag, OUT} = m_q;
`endif
  // in_ready depends only on registered skid state, never on out_ready
  assign in_ready = !sv_q && !rst;
  assign out_valid = mv_q;
  assign blk_count = cnt_q;
  assign acc = in_valid && in_ready;
  assign emit = mv_q && out_ready;
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    mv_d = mv_q;
    sv_d = sv_q;
    if (emit && sv_q) begin
      m_d = s_q;
      sv_d = 1'b0;
    end else if (acc && (!mv_q || emit)) begin
      m_d = beat;
      mv_d = 1'b1;
    end else if (acc) begin
      s_d = beat;
      sv_d = 1'b1;
    end else if (emit) begin
      mv_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      s_q <= '0;
      mv_q <= 1'b0;
      sv_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
      mv_q <= mv_d;
      sv_q <= sv_d;
      cnt_q <= cnt_q + CNT_W'(acc);
    end
  end
endmodule

// File: tb/tb_aes_round0_stage.sv
// tb_aes_round0_stage: random and directed checks against a 2-deep FIFO reference model
module tb_aes_round0_stage;
  localparam int LANES = 2, DW = 256, TW = 4, CW = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, key_256 = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_key_256;
  logic [DW-1:0] IN = '0, OUT;
  logic [255:0] KEY = '0;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic [CW-1:0] blk_count;
`ifdef AES_ROUND0_PARITY_EN
  logic [DW/8-1:0] out_parity;
`endif
  typedef struct packed {
    logic [DW/8-1:0] p;
    logic k;
    logic [TW-1:0] t;
    logic [DW-1:0] d;
  } beat_t;
  beat_t q[$];
  logic [CW-1:0] cnt = '0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  aes_round0_stage #(.BLOCK_LENGTH(128), .LANES(LANES), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .IN(IN), .KEY(KEY),
    .key_256(key_256), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .OUT(OUT), .out_key_256(out_key_256), .out_tag(out_tag), .blk_count(blk_count)
`ifdef AES_ROUND0_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  function automatic beat_t mk();
    beat_t b;
    logic [127:0] rk;
    rk = key_256 ? KEY[255:128] : KEY[127:0];
    b.d = '0;
    for (int l = 0; l < LANES; l++) b.d[l*128 +: 128] = IN[l*128 +: 128] ^ rk;
    for (int j = 0; j < DW/8; j++) b.p[j] = ^b.d[j*8 +: 8];
    b.k = key_256;
    b.t = in_tag;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: a FIFO of capacity 2; ready whenever it is not full
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cnt <= '0;
    end else if (in_valid && q.size() < 2) begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      q.push_back(mk());
      cnt <= cnt + 1'b1;
    end else if (q.size() > 0 && out_ready) begin
      void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("in_ready", DW'(in_ready), DW'(!rst && q.size() < 2));
    chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
    chk("blk_count", DW'(blk_count), DW'(cnt));
    if (q.size() > 0) begin
      chk("OUT", OUT, q[0].d);
      chk("out_tag", DW'(out_tag), DW'(q[0].t));
      chk("out_key_256", DW'(out_key_256), DW'(q[0].k));
`ifdef AES_ROUND0_PARITY_EN
      chk("out_parity", DW'(out_parity), DW'(q[0].p));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in();
    for (int i = 0; i < 8; i++) begin
      IN[i*32 +: 32] = $urandom();
      KEY[i*32 +: 32] = $urandom();
    end
    key_256 = 1'($urandom_range(1));
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_OUT", OUT, '0);
    chk("rst_blk_count", DW'(blk_count), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));
    rnd_in();
    IN[127:0] = 128'h3243f6a8885a308d313198a2e0370734;
    KEY[127:0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_256 = 1'b0;
    in_tag = 4'd5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fips_b_OUT", DW'(OUT[127:0]), DW'(128'h193de3bea0f4e22b9ac68d2ae9f84808));
    chk("fips_b_tag", DW'(out_tag), DW'(5));
    chk("fips_b_k256", DW'(out_key_256), '0);
    chk("fips_b_blk", DW'(blk_count), DW'(1));
`ifdef AES_ROUND0_PARITY_EN
    chk("fips_b_parity0", DW'(out_parity[0]), DW'(1));
`endif
    IN[127:0] = 128'h00112233445566778899aabbccddeeff;
    KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    key_256 = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("c3_OUT", DW'(OUT[127:0]), DW'(128'h00102030405060708090a0b0c0d0e0f0));
    chk("c3_k256", DW'(out_key_256), DW'(1));
    chk("c3_blk", DW'(blk_count), DW'(2));
    // back-pressure: two beats fill M and S, third stalls
    reset_dut();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      rnd_in();
      in_tag = TW'(i);
      in_valid = 1'b1;
      tick();
      chk("bp_hold_tag", DW'(out_tag), DW'(1));
    end
    chk("bp_in_ready_low", DW'(in_ready), '0);
    chk("bp_blk", DW'(blk_count), DW'(2));
    out_ready = 1'b1;
    tick();
    chk("bp_tag2", DW'(out_tag), DW'(2));
    tick();
    in_valid = 1'b0;
    chk("bp_tag3", DW'(out_tag), DW'(3));
    chk("bp_blk3", DW'(blk_count), DW'(3));
    tick();
    chk("bp_drained", DW'(out_valid), '0);
    // streaming
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      rnd_in();
      in_tag = TW'(i);
      in_valid = 1'b1;
      tick();
      chk("stream_valid", DW'(out_valid), DW'(1));
      chk("stream_tag", DW'(out_tag), DW'(i));
      chk("stream_ready", DW'(in_ready), DW'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_blk", DW'(blk_count), DW'(10));
    // reset with M and S full
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rnd_in();
      in_tag = TW'(i + 8);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_full", DW'(in_ready), '0);
    rst = 1'b1;
    tick();
    chk("mid_out_valid", DW'(out_valid), '0);
    chk("mid_OUT", OUT, '0);
    chk("mid_blk", DW'(blk_count), '0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mid_in_ready", DW'(in_ready), DW'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_old", DW'(out_valid), '0);
    end
    // counter wrap with 4-bit counter
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      rnd_in();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_blk", DW'(blk_count), DW'(1));
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(63) == 0);
      in_valid = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      rnd_in();
      in_tag = TW'($urandom());
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
